// File: rtl/remote_frame_pkg.sv
// Shared constants and FSM state type for the remote-control frame decoder.
package remote_frame_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } frame_state_e;

endpackage

// File: rtl/remote_sync_detector.sv
// Sliding-window sync detector: shifts in serial bits and flags a match once
// at least SYNC_WIDTH bits have arrived since the last clear.
module remote_sync_detector #(
    parameter int                    SYNC_WIDTH   = 4,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'b0101
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic shift_en,
    input  logic din,
    output logic match
);
    import remote_frame_pkg::*;

    localparam int             FW   = $clog2(SYNC_WIDTH) + 1;
    localparam logic [FW-1:0]  FULL = FW'(SYNC_WIDTH);

    logic [SYNC_WIDTH-1:0] sreg_q, sreg_d, shifted;
    logic [FW-1:0]         fill_q, fill_d;

    // The match looks at the window including the bit sampled on this edge.
    always_comb begin
        shifted = SYNC_WIDTH'({sreg_q, din});
        sreg_d  = sreg_q;
        fill_d  = fill_q;
        if (clear) begin
            sreg_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            sreg_d = shifted;
            if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
        match = shift_en && !clear && (fill_d == FULL) && (shifted == SYNC_PATTERN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            fill_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/remote_frame_decoder.sv
// Serial remote-control frame decoder: sync hunt, payload shift-in, optional
// parity check, then a one-cycle strobe (good frame) or perr (bad parity).
module remote_frame_decoder #(
    parameter int                    SYNC_WIDTH   = 4,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'b0101,
    parameter int                    DATA_WIDTH   = 4,
    parameter int                    PARITY       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  strobe,
    output logic                  perr,
    output logic                  busy
);
    import remote_frame_pkg::*;

    localparam int            CW   = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    frame_state_e          state_q, state_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-1:0] payload_q, payload_d, payload_shifted;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  strobe_q, strobe_d;
    logic                  perr_q, perr_d;
    logic                  match, sync_clear, sync_shift;
    logic                  finish, good;
    logic [DATA_WIDTH-1:0] word;

    // The detector only runs while hunting; holding it cleared during a frame
    // guarantees the next sync is built solely from bits after the frame.
    assign sync_clear = (state_q != HUNT);
    assign sync_shift = (state_q == HUNT);

    remote_sync_detector #(
        .SYNC_WIDTH   (SYNC_WIDTH),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .clear    (sync_clear),
        .shift_en (sync_shift),
        .din      (din),
        .match    (match)
    );

    always_comb begin
        state_d         = state_q;
        bitcnt_d        = bitcnt_q;
        payload_shifted = DATA_WIDTH'({payload_q, din});
        payload_d       = payload_q;
        dout_d          = dout_q;
        strobe_d        = 1'b0;
        perr_d          = 1'b0;
        finish          = 1'b0;
        good            = 1'b0;
        word            = payload_q;

        case (state_q)
            HUNT: begin
                if (match) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                payload_d = payload_shifted;
                bitcnt_d  = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST) begin
                    if (PARITY != PAR_NONE) begin
                        state_d = PAR;
                    end else begin
                        finish = 1'b1;
                        good   = 1'b1;
                        word   = payload_shifted;
                    end
                end
            end
            PAR: begin
                finish = 1'b1;
                word   = payload_q;
                if (PARITY == PAR_ODD) begin
                    good = (^{payload_q, din});
                end else begin
                    good = !(^{payload_q, din});
                end
            end
            default: state_d = HUNT;
        endcase

        // A bad frame leaves dout untouched so the consumer keeps the last good word.
        if (finish) begin
            state_d = HUNT;
            if (good) begin
                dout_d   = word;
                strobe_d = 1'b1;
            end else begin
                perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            bitcnt_q  <= '0;
            payload_q <= '0;
            dout_q    <= '0;
            strobe_q  <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            payload_q <= payload_d;
            dout_q    <= dout_d;
            strobe_q  <= strobe_d;
            perr_q    <= perr_d;
        end
    end

    assign dout   = dout_q;
    assign strobe = strobe_q;
    assign perr   = perr_q;
    assign busy   = (state_q != HUNT);

endmodule
